// File: rtl/user_io_host_if.sv
`default_nettype none
// ============================================================================
// Module   : user_io_host_if
// Purpose  : Host-side request/status bundle for the user_io SPI master.
//            master = requester (soft controller / testbench),
//            slave  = user_io_host itself.
// Revision : 1.0 - initial release
// ============================================================================
interface user_io_host_if;
   logic        req;
   logic [7:0]  cmd;
   logic [2:0]  len;
   logic [31:0] payload;
   logic        busy;
   logic        done;
   logic [31:0] rx_data;

   modport master (
      output req, cmd, len, payload,
      input  busy, done, rx_data
   );

   modport slave (
      input  req, cmd, len, payload,
      output busy, done, rx_data
   );
endinterface
`default_nettype wire

// File: rtl/user_io_host.sv
`default_nettype none
// ============================================================================
// Module   : user_io_host
// Purpose  : SPI mode-0 master that frames a command byte plus 0-4 payload
//            bytes (MSB first) onto the user_io configuration channel.
// Options  : USER_IO_HOST_MISO_EN - when defined, rx_data shifts in
//            spi_miso on every sample; otherwise rx_data is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module user_io_host #(
   parameter int CLK_DIV = 4,   // system clocks per SCK half-period (>=1)
   parameter int GAP     = 8    // system clocks select stays high between frames (>=1)
) (
   input  wire logic     clk,
   input  wire logic     _rst,
   user_io_host_if.slave host,
   output logic          spi_sck,
   output logic          spi_ss,
   output logic          spi_mosi,
   input  wire logic     spi_miso
);

   localparam int            CNT_MAX   = (CLK_DIV > GAP) ? CLK_DIV : GAP;
   localparam int            CW        = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOW  = 3'd1,
      S_HIGH = 3'd2,
      S_TAIL = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;          // cycles left in current state, minus one
   logic [5:0]    bit_cnt, bit_cnt_nxt;  // bits still to send
   logic [39:0]   shreg, shreg_nxt;      // outgoing frame, MSB on the wire
   logic [5:0]    n_bits;
   logic          sample;                // first HIGH cycle: capture MISO
   logic          active;

   // Frame length in bits: command byte plus len payload bytes, len clamped to 4.
   always_comb n_bits = (host.len > 3'd4) ? 6'd40 : ({host.len, 3'b000} + 6'd8);

   // State, timing counters and shift register.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // Next-state logic; the half-period counter reloads on every state entry.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      sample      = 1'b0;
      case (state)
         S_IDLE: begin
            if (host.req) begin
               state_nxt   = S_LOW;
               cnt_nxt     = HALF_LOAD;
               bit_cnt_nxt = n_bits;
               shreg_nxt   = {host.cmd, host.payload};
            end
         end
         S_LOW: begin
            if (cnt == '0) begin
               state_nxt = S_HIGH;
               cnt_nxt   = HALF_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_HIGH: begin
            sample = (cnt == HALF_LOAD);
            if (cnt == '0) begin
               shreg_nxt   = {shreg[38:0], 1'b0};
               bit_cnt_nxt = bit_cnt - 6'd1;
               cnt_nxt     = HALF_LOAD;
               state_nxt   = (bit_cnt == 6'd1) ? S_TAIL : S_LOW;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_TAIL: begin
            if (cnt == '0) begin
               state_nxt = S_GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pins decode straight from state so reset releases select and SCK at once.
   assign active    = (state == S_LOW) || (state == S_HIGH) || (state == S_TAIL);
   assign spi_sck   = (state == S_HIGH);
   assign spi_ss    = ~active;
   assign spi_mosi  = active & shreg[39];
   assign host.done = (state == S_GAP) && (cnt == '0);
   assign host.busy = (state != S_IDLE) && !host.done;

`ifdef USER_IO_HOST_MISO_EN
   logic [31:0] rx_q;

   // MISO capture: cleared on acceptance, shifts MSB-first on each sample.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         rx_q <= '0;
      end else if (state == S_IDLE && host.req) begin
         rx_q <= '0;
      end else if (sample) begin
         rx_q <= {rx_q[30:0], spi_miso};
      end
   end

   assign host.rx_data = rx_q;
`else
   logic unused_capture;
   assign unused_capture = spi_miso | sample;
   assign host.rx_data   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_user_io_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_user_io_host
// Purpose  : Self-checking bench for user_io_host. Each frame is compared
//            against a bit-level reference built from the command/payload
//            and the frame timing formulas.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_io_host;
   localparam int CLK_DIV = 2;
   localparam int GAP     = 8;
   localparam int BUDGET  = 2000;

   logic clk  = 1'b0;
   logic _rst = 1'b0;
   logic spi_sck, spi_ss, spi_mosi;
   logic spi_miso = 1'b0;
   int   tests = 0;
   int   fails = 0;

   user_io_host_if h();

   user_io_host #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
      .clk      (clk),
      ._rst     (_rst),
      .host     (h.slave),
      .spi_sck  (spi_sck),
      .spi_ss   (spi_ss),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One frame: request, observe every cycle, compare against the reference.
   task automatic run_txn(input logic [7:0] c, input logic [2:0] l, input logic [31:0] p,
                          input logic [39:0] miso_word, input bit poke, input bit hold);
      int          n, cyc, rises, ss_low, first_low, last_low, done_at;
      int          busy_bad, mosi_glitch, high_run, stray, k;
      logic        busy_at_done, prev_sck, mosi_at_rise;
      logic [39:0] got, exp_bits;
      logic [31:0] rx_seen, exp_rx;

      n        = 8 * (1 + ((l > 3'd4) ? 4 : int'(l)));
      exp_bits = {c, p} >> (40 - n);
`ifdef USER_IO_HOST_MISO_EN
      exp_rx   = 32'(miso_word & ((40'd1 << n) - 40'd1));
`else
      exp_rx   = 32'h0;
`endif
      cyc = 0; rises = 0; ss_low = 0; first_low = -1; last_low = -1; done_at = -1;
      busy_bad = 0; mosi_glitch = 0; busy_at_done = 1'b1; prev_sck = 1'b0;
      mosi_at_rise = 1'b0; got = '0; rx_seen = '0;

      @(negedge clk);
      h.req = 1'b1; h.cmd = c; h.len = l; h.payload = p;
      spi_miso = miso_word[n-1];
      @(posedge clk);
      while (done_at < 0 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (!hold) h.req = poke && (cyc % 7 == 3);
         if (spi_ss == 1'b0) begin
            ss_low++;
            if (first_low < 0) first_low = cyc;
            last_low = cyc;
         end
         if (spi_sck && !prev_sck) begin
            got = {got[38:0], spi_mosi};
            rises++;
            mosi_at_rise = spi_mosi;
         end else if (spi_sck && spi_mosi !== mosi_at_rise) begin
            mosi_glitch++;
         end
         prev_sck = spi_sck;
         if (!spi_sck) spi_miso = (rises < n) ? miso_word[n-1-rises] : 1'b0;
         if (h.done === 1'b1) begin
            done_at      = cyc;
            busy_at_done = h.busy;
            rx_seen      = h.rx_data;
         end else if (h.busy !== 1'b1) begin
            busy_bad++;
         end
      end
      h.req = hold;

      check("frame_bits", got, exp_bits);
      check("sck_pulses", rises, n);
      check("ss_first_low", first_low, 1);
      check("ss_low_cycles", ss_low, n * 2 * CLK_DIV + CLK_DIV);
      check("done_cycle", done_at, n * 2 * CLK_DIV + CLK_DIV + GAP);
      check("busy_at_done", busy_at_done, 1'b0);
      check("busy_during", busy_bad, 0);
      check("mosi_stable_high", mosi_glitch, 0);
      check("rx_data", rx_seen, exp_rx);

      if (hold) begin
         high_run = cyc - last_low;
         k = 0;
         while (k < BUDGET) begin
            @(negedge clk);
            k++;
            if (spi_ss) high_run++;
            else break;
         end
         h.req = 1'b0;
         check("ss_high_spacing", high_run, GAP + 1);
         k = 0;
         while (h.done !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
         end
         check("second_done_seen", h.done, 1'b1);
      end

      // With req low the block must stay idle: no select, busy or done.
      stray = 0;
      for (int i = 0; i < 2 * GAP; i++) begin
         @(negedge clk);
         if (spi_ss !== 1'b1 || h.busy !== 1'b0 || h.done !== 1'b0) stray++;
      end
      check("idle_after_done", stray, 0);
   endtask

   initial begin : main
      int          rises;
      int          k;
      logic        prev;
      logic [7:0]  rc;
      logic [2:0]  rl;
      logic [31:0] rp;
      logic [39:0] rm;

      h.req = 1'b0; h.cmd = '0; h.len = '0; h.payload = '0;

      // Reset state while reset is held.
      repeat (2) @(negedge clk);
      check("rst_sck", spi_sck, 1'b0);
      check("rst_ss", spi_ss, 1'b1);
      check("rst_mosi", spi_mosi, 1'b0);
      check("rst_busy", h.busy, 1'b0);
      check("rst_done", h.done, 1'b0);
      check("rst_rx", h.rx_data, 32'h0);
      _rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frames.
      run_txn(8'h01, 3'd1, 32'h2A00_0000, 40'h0, 1'b0, 1'b0);
      run_txn(8'h05, 3'd0, 32'hFFFF_FFFF, 40'hFF, 1'b0, 1'b0);
      run_txn(8'h04, 3'd7, 32'hDEAD_BEEF, 40'h12_3456_789A, 1'b0, 1'b0);
      run_txn(8'hC3, 3'd3, 32'h1234_5678, 40'hA5_A5A5_A5A5, 1'b0, 1'b0);
      run_txn(8'h81, 3'd2, 32'h8001_7FFE, 40'h0, 1'b1, 1'b0);
      run_txn(8'h3C, 3'd1, 32'h5500_0000, 40'hFFFF, 1'b0, 1'b1);

      // Reset asserted while SCK is high for bit 5.
      @(negedge clk);
      h.req = 1'b1; h.cmd = 8'hFF; h.len = 3'd4; h.payload = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      h.req = 1'b0;
      rises = 0; prev = 1'b0; k = 0;
      while (k < BUDGET) begin
         if (spi_sck && !prev) rises++;
         prev = spi_sck;
         if (rises == 5 && spi_sck) break;
         @(negedge clk);
         k++;
      end
      check("mid_rst_reached_bit5", rises, 5);
      #1 _rst = 1'b0;
      #1;
      check("mid_rst_ss", spi_ss, 1'b1);
      check("mid_rst_sck", spi_sck, 1'b0);
      check("mid_rst_busy", h.busy, 1'b0);
      @(negedge clk);
      _rst = 1'b1;
      @(negedge clk);
      run_txn(8'h5A, 3'd4, 32'h0F0F_C3C3, 40'h99_8877_6655, 1'b0, 1'b0);

      // Randomised frames.
      for (int i = 0; i < 8; i++) begin
         rc = 8'($urandom);
         rl = 3'($urandom_range(0, 7));
         rp = $urandom;
         rm = {8'($urandom), $urandom};
         run_txn(rc, rl, rp, rm, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/user_io_host.md
# user_io_host

SPI master that drives the user_io configuration channel from inside the FPGA: it frames a command byte plus 0–4 payload bytes onto SCK/MOSI under an active-low select, MSB first, SPI mode 0. It replaces the external MCU as the source of joystick, keyboard and mouse packets for on-chip soft-controller builds and for simulation. It sits in the 28 MHz domain and feeds the SPI_SCK/SPI_DI/CONF_DATA0 inputs that user_io decodes.

## Interface
- CLK_DIV, 4, system clocks per SCK half-period (≥1).
- GAP, 8, minimum system clocks select stays high between transactions (≥1).
- clk  in  1  system clock (28 MHz domain); one clock, all logic on rising edge.
- _rst  in  1  asynchronous active-low reset.
- req  in  1  start request; sampled only in IDLE.
- cmd  in  8  command byte (e.g. 0x01 buttons, 0x04 mouse, 0x05 keyboard).
- len  in  3  payload byte count; values >4 are treated as 4.
- payload  in  32  payload, byte 0 = [31:24], sent first.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at the end of the transaction.
- rx_data  out  32  MISO capture (see Configuration).
- spi_sck  out  1  SPI clock, idle low.
- spi_ss  out  1  select to user_io, active low.
- spi_mosi  out  1  serial data to user_io.
- spi_miso  in  1  serial data from user_io.

## Operation
- Reset values: spi_sck=0, spi_ss=1, spi_mosi=0, busy=0, done=0, rx_data=0; FSM in IDLE. Reset asserted mid-transaction releases spi_ss and spi_sck immediately, with no partial-frame completion.
- States: IDLE → LOW → HIGH → (LOW … ) → TAIL → GAP → IDLE.
- IDLE: when req=1, latch {cmd, payload}, set bit count N=8·(1+min(len,4)), assert spi_ss, drive spi_mosi=cmd[7], set busy. Go to LOW.
- LOW: spi_sck=0 for CLK_DIV cycles, then go to HIGH.
- HIGH: spi_sck=1 for CLK_DIV cycles. spi_miso is sampled on the first HIGH cycle. At the end of HIGH, the shift register advances and the bit counter decrements. If bits remain, spi_mosi takes the next bit and the FSM goes to LOW; otherwise it goes to TAIL.
- TAIL: spi_sck=0 for CLK_DIV cycles with spi_ss still low, then spi_ss=1 and go to GAP.
- GAP: hold spi_ss high for GAP cycles. On the last cycle, pulse done and drop busy; return to IDLE.
- req while busy is ignored and not queued. req held high after done starts the next transaction on the first IDLE cycle.
- len=0 sends the command byte only: N=8.
- Bit counter is 6 bits wide and counts down from N to 0 with no wrap.
- Half-period counter is reloaded at every state entry.

## Timing
- Acceptance edge = cycle 0. spi_ss=0, busy=1, spi_mosi=MSB are valid from cycle 1.
- First SCK rise at cycle 1+CLK_DIV. Each bit occupies 2·CLK_DIV cycles. MOSI changes only while SCK is low, aligned with the falling edge.
- spi_ss low for N·2·CLK_DIV + CLK_DIV cycles.
- done pulse at cycle N·2·CLK_DIV + CLK_DIV + GAP. busy falls on that same edge.
- Minimum spacing between consecutive select assertions is GAP+1 cycles high.

## Configuration
- USER_IO_HOST_MISO_EN defined: rx_data is a 32-bit shift register that shifts in spi_miso MSB-first on each sample. It is cleared at acceptance and holds the last 32 bits received, updated in place until done.
- USER_IO_HOST_MISO_EN undefined: rx_data is constant 0, spi_miso is unused, and no capture flops are synthesized.

## Test plan
- Reset during HIGH of bit 5 (CLK_DIV=4) → spi_ss=1 and spi_sck=0 in the same cycle asynchronously. busy=0. A new req after release sends a full frame.
- CLK_DIV=2, GAP=8, cmd=0x01, len=1, payload=0x2A000000 → MOSI bits 00000001_00101010 sampled on SCK rises. spi_ss low 66 cycles. done at cycle 74.
- cmd=0x05, len=0 → exactly 8 SCK pulses; spi_ss low 8·2·CLK_DIV+CLK_DIV cycles.
- len=7, payload=0xDEADBEEF, cmd=0x04 → 40 bits sent: 0x04DEADBEEF. No extra pulses.
- req toggled high during busy → no effect. req held high → second transaction's spi_ss falls exactly GAP+1 cycles after the first's rise.
- With USER_IO_HOST_MISO_EN, spi_miso driven with 0xA5 pattern during a len=3 frame → rx_data=0x??A5A5A5 low 24 bits. Without the macro, rx_data=0.
